// File: rtl/bus_arbiter_pkg.sv
// Shared bus widths, control encodings and FSM state encodings for the
// instruction-fetch / data-access bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned RegBus      = 32;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned SelBus      = 4;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusyIf  = 2'd1,
    StBusyMem = 2'd2,
    StDone    = 2'd3
  } state_e;

  typedef enum logic {
    GrantIf  = 1'b0,
    GrantMem = 1'b1
  } grant_e;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access,
// with fair alternation under contention and a bus wait timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   if_req_i,
  input  logic [InstAddrBus-1:0] if_addr_i,
  output logic [RegBus-1:0]      if_rdata_o,
  output logic                   if_ack_o,

  input  logic                   mem_req_i,
  input  logic                   mem_we_i,
  input  logic [SelBus-1:0]      mem_sel_i,
  input  logic [RegBus-1:0]      mem_addr_i,
  input  logic [RegBus-1:0]      mem_wdata_i,
  output logic [RegBus-1:0]      mem_rdata_o,
  output logic                   mem_ack_o,

  output logic                   bus_ce_o,
  output logic                   bus_we_o,
  output logic [SelBus-1:0]      bus_sel_o,
  output logic [RegBus-1:0]      bus_addr_o,
  output logic [RegBus-1:0]      bus_wdata_o,
  input  logic [RegBus-1:0]      bus_rdata_i,
  input  logic                   bus_ready_i,

  output logic                   stallreq_o,
  output logic                   err_o
);

  // Timeout fires on the edge where the wait counter would reach TIMEOUT_CYCLES.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  grant_e              last_q, last_d;
  logic [7:0]          wait_q, wait_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic [SelBus-1:0]   sel_q, sel_d;
  logic [RegBus-1:0]   addr_q, addr_d;
  logic [RegBus-1:0]   wdata_q, wdata_d;
  logic [RegBus-1:0]   if_rdata_q, if_rdata_d;
  logic [RegBus-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                err_q, err_d;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wait_d      = wait_q;
    ce_d        = ce_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        // Under contention the requester not served last wins.
        if (mem_req_i && (!if_req_i || (last_q == GrantIf))) begin
          state_d = StBusyMem;
          last_d  = GrantMem;
          wait_d  = 8'd0;
          ce_d    = ChipEnable;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
        end else if (if_req_i) begin
          state_d = StBusyIf;
          last_d  = GrantIf;
          wait_d  = 8'd0;
          ce_d    = ChipEnable;
          we_d    = WriteDisable;
          sel_d   = 4'b1111;
          addr_d  = if_addr_i;
          wdata_d = '0;
        end
      end
      StBusyIf, StBusyMem: begin
        if (bus_ready_i || (wait_q == TimeoutLast)) begin
          state_d = StDone;
          ce_d    = ChipDisable;
          err_d   = ~bus_ready_i;
          if (state_q == StBusyIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_ready_i ? bus_rdata_i : '0;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = bus_ready_i ? bus_rdata_i : '0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= GrantIf;
      wait_q      <= 8'd0;
      ce_q        <= ChipDisable;
      we_q        <= WriteDisable;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wait_q      <= wait_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_ce_o    = ce_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign err_o       = err_q;

  assign stallreq_o = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: table of per-cycle vectors plus hand-written
// write, timeout, reset-mid-access and stall sequences.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_sel_i = 4'hf;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ready_i = 1'b0;
  logic        stallreq_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ack_o   (if_ack_o),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_sel_i  (mem_sel_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ack_o  (mem_ack_o),
    .bus_ce_o   (bus_ce_o),
    .bus_we_o   (bus_we_o),
    .bus_sel_o  (bus_sel_o),
    .bus_addr_o (bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ready_i(bus_ready_i),
    .stallreq_o (stallreq_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        ready;
    logic [31:0] rdata;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_if_ack;
    logic        e_mem_ack;
    logic        e_stall;
    logic [31:0] e_if_rdata;
    logic [31:0] e_mem_rdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic mr, logic [31:0] ma, logic rdy,
                              logic [31:0] rd, logic ce, logic [31:0] ad, logic ika,
                              logic mka, logic st, logic [31:0] ird, logic [31:0] mrd);
    vec_t v;
    v.if_req = ir;   v.if_addr = ia;   v.mem_req = ma == 32'h0 ? mr : mr;
    v.mem_addr = ma; v.ready = rdy;    v.rdata = rd;
    v.e_ce = ce;     v.e_addr = ad;    v.e_if_ack = ika;
    v.e_mem_ack = mka; v.e_stall = st; v.e_if_rdata = ird; v.e_mem_rdata = mrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fetch, then four contended accesses alternating MEM, IF, MEM, IF.
    vecs[0]  = mk(1, 32'h100, 0, 32'h000, 0, 32'h0,        1, 32'h100, 0, 0, 1, 32'h0,        32'h0);
    vecs[1]  = mk(1, 32'h100, 0, 32'h000, 1, 32'h34011100, 0, 32'h100, 1, 0, 0, 32'h34011100, 32'h0);
    vecs[2]  = mk(0, 32'h100, 0, 32'h000, 0, 32'h0,        0, 32'h100, 0, 0, 0, 32'h34011100, 32'h0);
    vecs[3]  = mk(1, 32'h104, 1, 32'h300, 0, 32'h0,        1, 32'h300, 0, 0, 1, 32'h34011100, 32'h0);
    vecs[4]  = mk(1, 32'h104, 1, 32'h300, 1, 32'hAAAA0001, 0, 32'h300, 0, 1, 1, 32'h34011100, 32'hAAAA0001);
    vecs[5]  = mk(1, 32'h104, 1, 32'h300, 1, 32'h12345678, 0, 32'h300, 0, 0, 1, 32'h34011100, 32'hAAAA0001);
    vecs[6]  = mk(1, 32'h104, 1, 32'h300, 0, 32'h0,        1, 32'h104, 0, 0, 1, 32'h34011100, 32'hAAAA0001);
    vecs[7]  = mk(1, 32'h104, 1, 32'h300, 1, 32'hBBBB0002, 0, 32'h104, 1, 0, 1, 32'hBBBB0002, 32'hAAAA0001);
    vecs[8]  = mk(1, 32'h104, 1, 32'h300, 1, 32'h87654321, 0, 32'h104, 0, 0, 1, 32'hBBBB0002, 32'hAAAA0001);
    vecs[9]  = mk(1, 32'h104, 1, 32'h300, 0, 32'h0,        1, 32'h300, 0, 0, 1, 32'hBBBB0002, 32'hAAAA0001);
    vecs[10] = mk(1, 32'h104, 1, 32'h300, 1, 32'hCCCC0003, 0, 32'h300, 0, 1, 1, 32'hBBBB0002, 32'hCCCC0003);
    vecs[11] = mk(1, 32'h104, 1, 32'h300, 0, 32'h0,        0, 32'h300, 0, 0, 1, 32'hBBBB0002, 32'hCCCC0003);
    vecs[12] = mk(1, 32'h104, 1, 32'h300, 0, 32'h0,        1, 32'h104, 0, 0, 1, 32'hBBBB0002, 32'hCCCC0003);
    vecs[13] = mk(1, 32'h104, 1, 32'h300, 1, 32'hDDDD0004, 0, 32'h104, 1, 0, 1, 32'hDDDD0004, 32'hCCCC0003);
    vecs[14] = mk(0, 32'h104, 0, 32'h300, 1, 32'hFFFFFFFF, 0, 32'h104, 0, 0, 0, 32'hDDDD0004, 32'hCCCC0003);
    vecs[15] = mk(0, 32'h104, 0, 32'h300, 1, 32'hFFFFFFFF, 0, 32'h104, 0, 0, 0, 32'hDDDD0004, 32'hCCCC0003);

    // Reset state, with stall still combinational from the requests.
    if_req_i = 1'b1;
    step();
    step();
    chk("rst_ce", {31'b0, bus_ce_o}, 32'h0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_acks", {30'b0, if_ack_o, mem_ack_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'h0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'h1);
    if_req_i = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_ce", {31'b0, bus_ce_o}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if_req_i    = vecs[i].if_req;
      if_addr_i   = vecs[i].if_addr;
      mem_req_i   = vecs[i].mem_req;
      mem_addr_i  = vecs[i].mem_addr;
      mem_we_i    = 1'b0;
      mem_sel_i   = 4'hf;
      bus_ready_i = vecs[i].ready;
      bus_rdata_i = vecs[i].rdata;
      step();
      chk($sformatf("v%0d_ce", i), {31'b0, bus_ce_o}, {31'b0, vecs[i].e_ce});
      chk($sformatf("v%0d_we", i), {31'b0, bus_we_o}, 32'h0);
      chk($sformatf("v%0d_addr", i), bus_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_if_ack", i), {31'b0, if_ack_o}, {31'b0, vecs[i].e_if_ack});
      chk($sformatf("v%0d_mem_ack", i), {31'b0, mem_ack_o}, {31'b0, vecs[i].e_mem_ack});
      chk($sformatf("v%0d_err", i), {31'b0, err_o}, 32'h0);
      chk($sformatf("v%0d_stall", i), {31'b0, stallreq_o}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_if_rdata", i), if_rdata_o, vecs[i].e_if_rdata);
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata_o, vecs[i].e_mem_rdata);
    end
    bus_ready_i = 1'b0;

    // Write access.
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h200; mem_wdata_i = 32'hDEADBEEF;
    step();
    chk("wr_ce", {31'b0, bus_ce_o}, 32'h1);
    chk("wr_we", {31'b0, bus_we_o}, 32'h1);
    chk("wr_sel", {28'b0, bus_sel_o}, 32'h3);
    chk("wr_addr", bus_addr_o, 32'h200);
    chk("wr_wdata", bus_wdata_o, 32'hDEADBEEF);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h55;
    step();
    chk("wr_ack", {31'b0, mem_ack_o}, 32'h1);
    chk("wr_err", {31'b0, err_o}, 32'h0);
    chk("wr_ce_drop", {31'b0, bus_ce_o}, 32'h0);
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'hf; bus_ready_i = 1'b0;
    step();

    // Fetch right after a write must drive we=0, sel=1111.
    if_req_i = 1'b1; if_addr_i = 32'h108;
    step();
    chk("fe_we", {31'b0, bus_we_o}, 32'h0);
    chk("fe_sel", {28'b0, bus_sel_o}, 32'hf);
    chk("fe_addr", bus_addr_o, 32'h108);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h1;
    step();
    chk("fe_ack", {31'b0, if_ack_o}, 32'h1);
    if_req_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Timeout with TIMEOUT_CYCLES=4: ack+err in the 5th cycle after grant.
    mem_req_i = 1'b1; mem_addr_i = 32'h400;
    step();
    chk("to_grant_ce", {31'b0, bus_ce_o}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("to_wait%0d", i), {29'b0, bus_ce_o, mem_ack_o, err_o}, 32'h4);
    end
    step();
    chk("to_ack", {31'b0, mem_ack_o}, 32'h1);
    chk("to_err", {31'b0, err_o}, 32'h1);
    chk("to_rdata", mem_rdata_o, 32'h0);
    chk("to_ce", {31'b0, bus_ce_o}, 32'h0);
    mem_req_i = 1'b0;
    step();
    chk("to_err_clr", {30'b0, mem_ack_o, err_o}, 32'h0);
    mem_req_i = 1'b1; mem_addr_i = 32'h404;
    step();
    chk("to_next_addr", bus_addr_o, 32'h404);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h77;
    step();
    chk("to_next_ack", {30'b0, mem_ack_o, err_o}, 32'h2);
    chk("to_next_rdata", mem_rdata_o, 32'h77);
    mem_req_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Reset asserted mid-access.
    mem_req_i = 1'b1; mem_addr_i = 32'h600;
    step();
    chk("rm_ce", {31'b0, bus_ce_o}, 32'h1);
    if_req_i = 1'b1; if_addr_i = 32'h10C;
    #2 rst = 1'b1;
    #1;
    chk("rm_ce_async", {31'b0, bus_ce_o}, 32'h0);
    chk("rm_addr", bus_addr_o, 32'h0);
    chk("rm_rdata", if_rdata_o | mem_rdata_o, 32'h0);
    chk("rm_stall", {31'b0, stallreq_o}, 32'h1);
    mem_req_i = 1'b0;
    step();
    chk("rm_no_ack", {30'b0, if_ack_o, mem_ack_o}, 32'h0);
    rst = 1'b0;
    step();
    chk("rm_if_grant_ce", {31'b0, bus_ce_o}, 32'h1);
    chk("rm_if_grant_addr", bus_addr_o, 32'h10C);
    bus_ready_i = 1'b1; bus_rdata_i = 32'h2;
    step();
    chk("rm_if_ack", {30'b0, if_ack_o, mem_ack_o}, 32'h2);
    if_req_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Stall across a 3-cycle bus wait; ready coincides with the timeout edge.
    mem_req_i = 1'b1; mem_addr_i = 32'h500;
    step();
    chk("st_grant", {30'b0, bus_ce_o, stallreq_o}, 32'h3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("st_wait%0d", i), {30'b0, stallreq_o, mem_ack_o}, 32'h2);
    end
    bus_ready_i = 1'b1; bus_rdata_i = 32'h99;
    step();
    chk("st_ack", {30'b0, mem_ack_o, err_o}, 32'h2);
    chk("st_rdata", mem_rdata_o, 32'h99);
    chk("st_stall_ack", {31'b0, stallreq_o}, 32'h0);
    mem_req_i = 1'b0; bus_ready_i = 1'b0;
    #1;
    chk("st_stall_drop", {31'b0, stallreq_o}, 32'h0);
    step();
    chk("st_idle", {30'b0, stallreq_o, mem_ack_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
